// File: rtl/regfile_wr_sched.sv
// rtl/regfile_wr_sched.sv - round-robin write-port scheduler with clear-all sequencer for the 8x16 register file
module regfile_wr_sched #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NREQ-1:0]          Req_Valid,
  input  logic [NREQ*ADDR_W-1:0]   Req_DR,
  input  logic [NREQ*DATA_W-1:0]   Req_Data,
  output logic [NREQ-1:0]          Req_Ready,
  input  logic                     Clear_Start,
  output logic                     Clear_Busy,
  output logic                     Clear_Done,
  output logic                     RF_Load,
  output logic [ADDR_W-1:0]        RF_DR,
  output logic [DATA_W-1:0]        RF_Data,
  output logic [1:0]               Grant_Id
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t     state;
  logic [1:0] last;
  logic [2:0] cnt;
  logic       sel_found;
  logic [1:0] sel_idx;
  int         idx;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    if (state == IDLE && !Clear_Start) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = int'(last) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!sel_found && Req_Valid[idx]) begin
          sel_found = 1'b1;
          sel_idx   = 2'(idx);
        end
      end
    end
    Req_Ready = sel_found ? (NREQ'(1) << sel_idx) : '0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      Clear_Busy <= 1'b0;
      Clear_Done <= 1'b0;
      RF_Load    <= 1'b0;
      RF_DR      <= '0;
      RF_Data    <= '0;
      Grant_Id   <= '0;
      last       <= 2'(NREQ - 1);
      cnt        <= '0;
    end else begin
      Clear_Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Clear_Start) begin
            state      <= CLEAR;
            Clear_Busy <= 1'b1;
            RF_Load    <= 1'b1;
            RF_DR      <= '0;
            RF_Data    <= '0;
            cnt        <= 3'd1;
          end else if (sel_found) begin
            RF_Load  <= 1'b1;
            RF_DR    <= Req_DR[int'(sel_idx)*ADDR_W +: ADDR_W];
            RF_Data  <= Req_Data[int'(sel_idx)*DATA_W +: DATA_W];
            Grant_Id <= sel_idx;
            last     <= sel_idx;
          end else begin
            RF_Load <= 1'b0;
          end
        end
        CLEAR: begin
          // Counter wrapping to zero means R7 was already on the port.
          if (cnt != 3'd0) begin
            RF_Load <= 1'b1;
            RF_DR   <= ADDR_W'(cnt);
            RF_Data <= '0;
            cnt     <= cnt + 3'd1;
          end else begin
            state      <= IDLE;
            Clear_Busy <= 1'b0;
            RF_Load    <= 1'b0;
            Clear_Done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wr_sched.sv
// tb/tb_regfile_wr_sched.sv - directed-vector bench for regfile_wr_sched with an attached register file
module tb_regfile_wr_sched;

  logic        Clk;
  logic        Reset;
  logic [2:0]  Req_Valid;
  logic [8:0]  Req_DR;
  logic [47:0] Req_Data;
  logic [2:0]  Req_Ready;
  logic        Clear_Start;
  logic        Clear_Busy;
  logic        Clear_Done;
  logic        RF_Load;
  logic [2:0]  RF_DR;
  logic [15:0] RF_Data;
  logic [1:0]  Grant_Id;

  int vectors     = 0;
  int miscompares = 0;
  int prot_viol   = 0;

  logic [15:0] rf [8];
  logic        preload = 1'b0;

  logic [2:0]  pend = '0;
  logic [8:0]  pend_dr;
  logic [47:0] pend_data;

  regfile_wr_sched #(.NREQ(3), .DATA_W(16), .ADDR_W(3)) dut (
    .Clk(Clk), .Reset(Reset), .Req_Valid(Req_Valid), .Req_DR(Req_DR),
    .Req_Data(Req_Data), .Req_Ready(Req_Ready), .Clear_Start(Clear_Start),
    .Clear_Busy(Clear_Busy), .Clear_Done(Clear_Done), .RF_Load(RF_Load),
    .RF_DR(RF_DR), .RF_Data(RF_Data), .Grant_Id(Grant_Id)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (preload) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'hFFFF;
    end else if (RF_Load) begin
      rf[RF_DR] <= RF_Data;
    end
  end

  // Requester obligation: a pending request keeps Valid, DR and Data stable until granted.
  always @(negedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < 3; i++) begin
        if (pend[i] && (!Req_Valid[i] || Req_DR[i*3 +: 3] !== pend_dr[i*3 +: 3] ||
                        Req_Data[i*16 +: 16] !== pend_data[i*16 +: 16])) begin
          $display("FAIL req_stable requester %0d dropped or changed before transfer", i);
          prot_viol = prot_viol + 1;
        end
      end
    end
    pend      = Reset ? 3'b000 : (Req_Valid & ~Req_Ready);
    pend_dr   = Req_DR;
    pend_data = Req_Data;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset       = 1'b1;
    Req_Valid   = '0;
    Clear_Start = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Req_Valid = '0; Clear_Start = 1'b0;
    tick(); tick();
    vectors++;
    if ({Clear_Busy, Clear_Done, RF_Load, RF_DR, RF_Data, Grant_Id} !== 24'h0) begin
      $display("FAIL reset_outputs got busy=%b done=%b load=%b dr=%0d data=%h gid=%0d required all zero",
               Clear_Busy, Clear_Done, RF_Load, RF_DR, RF_Data, Grant_Id);
      miscompares++;
    end
    Reset = 1'b0;
    Req_Valid = 3'b111;
    #1;
    vectors++;
    if (Req_Ready !== 3'b001) begin
      $display("FAIL reset_priority got ready=%b required 001", Req_Ready);
      miscompares++;
    end
    Req_Valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    Req_Valid = 3'b010; Req_DR[5:3] = 3'd3; Req_Data[31:16] = 16'hBEEF;
    #1;
    vectors++;
    if (Req_Ready !== 3'b010) begin
      $display("FAIL single_ready got %b required 010", Req_Ready);
      miscompares++;
    end
    tick();
    Req_Valid = '0;
    vectors++;
    if ({RF_Load, RF_DR, RF_Data, Grant_Id} !== {1'b1, 3'd3, 16'hBEEF, 2'd1}) begin
      $display("FAIL single_write got load=%b dr=%0d data=%h gid=%0d required 1 3 beef 1",
               RF_Load, RF_DR, RF_Data, Grant_Id);
      miscompares++;
    end
    tick();
    vectors++;
    if ({RF_Load, RF_DR, RF_Data, Grant_Id} !== {1'b0, 3'd3, 16'hBEEF, 2'd1}) begin
      $display("FAIL single_hold got load=%b dr=%0d data=%h gid=%0d required 0 3 beef 1",
               RF_Load, RF_DR, RF_Data, Grant_Id);
      miscompares++;
    end
    vectors++;
    if (rf[3] !== 16'hBEEF) begin
      $display("FAIL single_commit got R3=%h required beef", rf[3]);
      miscompares++;
    end
  endtask

  task automatic test_round_robin();
    int exp_id;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      Req_DR[i*3 +: 3]    = 3'(i);
      Req_Data[i*16 +: 16] = 16'(16'h1000 + i);
    end
    Req_Valid = 3'b111;
    #1;
    for (int n = 0; n < 6; n++) begin
      exp_id = n % 3;
      vectors++;
      if (Req_Ready !== 3'(1 << exp_id)) begin
        $display("FAIL rr_ready step %0d got %b required one-hot bit %0d", n, Req_Ready, exp_id);
        miscompares++;
      end
      tick();
      vectors++;
      if ({RF_Load, RF_DR, RF_Data, Grant_Id} !== {1'b1, 3'(exp_id), 16'(16'h1000 + exp_id), 2'(exp_id)}) begin
        $display("FAIL rr_grant step %0d got load=%b dr=%0d data=%h gid=%0d required gid %0d",
                 n, RF_Load, RF_DR, RF_Data, Grant_Id, exp_id);
        miscompares++;
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    Req_DR[8:6] = 3'd6;
    Req_Valid = 3'b100;
    for (int n = 1; n <= 3; n++) begin
      Req_Data[47:32] = 16'(n);
      #1;
      vectors++;
      if (Req_Ready !== 3'b100) begin
        $display("FAIL b2b_ready beat %0d got %b required 100", n, Req_Ready);
        miscompares++;
      end
      tick();
      if (n == 3) Req_Valid = '0;
      vectors++;
      if ({RF_Load, RF_DR, RF_Data, Grant_Id} !== {1'b1, 3'd6, 16'(n), 2'd2}) begin
        $display("FAIL b2b_write beat %0d got load=%b dr=%0d data=%h gid=%0d required 1 6 %h 2",
                 n, RF_Load, RF_DR, RF_Data, Grant_Id, n);
        miscompares++;
      end
    end
    tick();
    vectors++;
    if (RF_Load !== 1'b0) begin
      $display("FAIL b2b_idle got load=%b required 0", RF_Load);
      miscompares++;
    end
  endtask

  task automatic test_clear();
    do_reset();
    preload = 1'b1;
    tick();
    preload = 1'b0;
    Clear_Start = 1'b1;
    Req_Valid = 3'b001; Req_DR[2:0] = 3'd5; Req_Data[15:0] = 16'hA5A5;
    #1;
    vectors++;
    if (Req_Ready !== 3'b000) begin
      $display("FAIL clear_blocks_ready got %b required 000", Req_Ready);
      miscompares++;
    end
    tick();
    Clear_Start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      vectors++;
      if ({Clear_Busy, Clear_Done, RF_Load, RF_DR, RF_Data, Req_Ready} !== {3'b101, 3'(k), 16'h0000, 3'b000}) begin
        $display("FAIL clear_step %0d got busy=%b done=%b load=%b dr=%0d data=%h ready=%b required 1 0 1 %0d 0000 000",
                 k, Clear_Busy, Clear_Done, RF_Load, RF_DR, RF_Data, Req_Ready, k);
        miscompares++;
      end
    end
    tick();
    vectors++;
    if ({Clear_Busy, Clear_Done, RF_Load, Req_Ready} !== {3'b010, 3'b001}) begin
      $display("FAIL clear_done got busy=%b done=%b load=%b ready=%b required 0 1 0 001",
               Clear_Busy, Clear_Done, RF_Load, Req_Ready);
      miscompares++;
    end
    tick();
    Req_Valid = '0;
    vectors++;
    if ({Clear_Done, RF_Load, RF_DR, RF_Data, Grant_Id} !== {2'b01, 3'd5, 16'hA5A5, 2'd0}) begin
      $display("FAIL clear_post_grant got done=%b load=%b dr=%0d data=%h gid=%0d required 0 1 5 a5a5 0",
               Clear_Done, RF_Load, RF_DR, RF_Data, Grant_Id);
      miscompares++;
    end
    for (int r = 0; r < 8; r++) begin
      vectors++;
      if (rf[r] !== 16'h0000) begin
        $display("FAIL clear_regs R%0d got %h required 0000", r, rf[r]);
        miscompares++;
      end
    end
    tick();
    vectors++;
    if (rf[5] !== 16'hA5A5) begin
      $display("FAIL clear_post_commit got R5=%h required a5a5", rf[5]);
      miscompares++;
    end
  endtask

  task automatic test_clear_restart_ignored();
    int done_cnt = 0;
    int done_at  = -1;
    do_reset();
    Clear_Start = 1'b1;
    tick();
    Clear_Start = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      Clear_Start = (e == 4);
      tick();
      if (Clear_Done === 1'b1) begin
        done_cnt++;
        done_at = e;
      end
    end
    Clear_Start = 1'b0;
    vectors++;
    if (done_cnt !== 1 || done_at !== 8) begin
      $display("FAIL clear_restart got %0d done pulses last at edge %0d required 1 at edge 8", done_cnt, done_at);
      miscompares++;
    end
    vectors++;
    if ({Clear_Busy, RF_Load} !== 2'b00) begin
      $display("FAIL clear_restart_idle got busy=%b load=%b required 0 0", Clear_Busy, RF_Load);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid_clear();
    int done_cnt = 0;
    do_reset();
    Clear_Start = 1'b1;
    tick();
    Clear_Start = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    vectors++;
    if ({RF_Load, Clear_Busy, Clear_Done} !== 3'b000) begin
      $display("FAIL midclear_abort got load=%b busy=%b done=%b required 0 0 0", RF_Load, Clear_Busy, Clear_Done);
      miscompares++;
    end
    for (int e = 0; e < 8; e++) begin
      tick();
      if (Clear_Done === 1'b1 || RF_Load === 1'b1) done_cnt++;
    end
    vectors++;
    if (done_cnt !== 0) begin
      $display("FAIL midclear_quiet got %0d active cycles required 0", done_cnt);
      miscompares++;
    end
    for (int i = 0; i < 3; i++) begin
      Req_DR[i*3 +: 3]     = 3'(i + 1);
      Req_Data[i*16 +: 16] = 16'(16'h2000 + i);
    end
    Req_Valid = 3'b111;
    #1;
    vectors++;
    if (Req_Ready !== 3'b001) begin
      $display("FAIL midclear_priority got ready=%b required 001", Req_Ready);
      miscompares++;
    end
    tick();
    vectors++;
    if ({RF_Load, RF_DR, RF_Data, Grant_Id} !== {1'b1, 3'd1, 16'h2000, 2'd0}) begin
      $display("FAIL midclear_first_grant got load=%b dr=%0d data=%h gid=%0d required 1 1 2000 0",
               RF_Load, RF_DR, RF_Data, Grant_Id);
      miscompares++;
    end
    do_reset();
  endtask

  initial begin
    Reset = 1'b1; Req_Valid = '0; Req_DR = '0; Req_Data = '0; Clear_Start = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_clear();
    test_clear_restart_ignored();
    test_reset_mid_clear();
    vectors++;
    if (prot_viol !== 0) begin
      $display("FAIL req_protocol got %0d violations required 0", prot_viol);
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
